mac_result_reader: RTL
======================

MAC_RESULT_READER -- requirements
Module: mac_result_reader

Interface
REQ-001 Parameter LEN, default 4, number of MAC enable cycles per result frame (legal range 1..255).
REQ-002 Parameter ACC_W, default 16, accumulator width read from the MAC.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to run one accumulation frame.
REQ-006 mac_rst  output  1  clear strobe driven to the MAC accumulator reset.
REQ-007 mac_en  output  1  enable driven to the MAC; one accumulate step per high cycle.
REQ-008 ac_val  input  ACC_W  MAC accumulator value; registered in the MAC, updates one edge after a mac_en-high edge.
REQ-009 cout  input  1  MAC accumulator carry-out.
REQ-010 res_data  output  ACC_W  captured accumulator result.
REQ-011 res_ovf  output  1  sticky overflow flag for the captured frame.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  consumer accepts the result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, CLR, RUN, SETTLE and OUT, with all outputs driven from registers or decoded from the state.
REQ-016 IDLE: start=1 SHALL move the FSM to CLR; start=0 SHALL keep it in IDLE.
REQ-017 In any state other than IDLE, start SHALL be ignored, with no queuing and no restart.
REQ-018 CLR SHALL last exactly one cycle with mac_rst=1 and mac_en=0, SHALL clear the step counter and the overflow sticky bit, and SHALL then move to RUN.
REQ-019 RUN SHALL hold mac_en=1 for exactly LEN consecutive cycles, counted by an 8-bit step counter, and SHALL then move to SETTLE.
REQ-020 SETTLE SHALL last one cycle with mac_en=0, so the last accumulate is visible on ac_val.
REQ-021 On the SETTLE->OUT edge, the block SHALL load res_data from ac_val and load res_ovf from the sticky bit OR cout.
REQ-022 The overflow sticky bit SHALL OR in cout on every RUN and SETTLE cycle.
REQ-023 OUT SHALL hold res_valid=1 with res_data and res_ovf stable until res_ready=1.
REQ-024 On an OUT edge with res_ready=1, the FSM SHALL return to IDLE, with res_valid=0 from the next cycle.
REQ-025 res_ready=1 outside OUT SHALL have no effect.
REQ-026 Latency: for start sampled at edge k, CLR SHALL occupy cycle k+1, RUN cycles k+2..k+LEN+1, SETTLE cycle k+LEN+2, and res_valid SHALL first be high at cycle k+LEN+3.
REQ-027 res_data and res_ovf SHALL hold their last captured values in IDLE; they SHALL change only on the SETTLE->OUT edge.
REQ-028 mac_rst and mac_en SHALL never be high in the same cycle.
REQ-029 With LEN=1, RUN SHALL last exactly one cycle.
REQ-030 The design SHALL be synthesizable with no latches and no combinational path from any input to any output.

Reset
REQ-031 While rst=1, asynchronously and independent of clk, the block SHALL force the state to IDLE and the step counter to 0.
REQ-032 While rst=1, the block SHALL force mac_rst=0, mac_en=0, res_valid=0, busy=0, res_data=0, res_ovf=0 and the sticky bit to 0.
REQ-033 Reset asserted mid-frame (CLR, RUN, SETTLE or OUT) SHALL abort the frame with no res_valid pulse.
REQ-034 The first start sampled after rst deasserts SHALL run a complete frame.

Verification
REQ-035 Bench with a MAC model (ac_val <= ac_val + a*b on mac_en, cleared on mac_rst), LEN=4, a=3, b=5, res_ready=1, start pulse -> mac_en high 4 cycles; res_data=60 (0x003C); res_ovf=0; res_valid high exactly 1 cycle at k+7.
REQ-036 Backpressure: same frame with res_ready=0 for 10 cycles after res_valid -> res_valid, res_data=60 and busy held steady; 1 cycle after res_ready=1, res_valid=0 and busy=0.
REQ-037 Overflow: a=255, b=255, LEN=4 -> 4*65025 wraps, cout pulses; res_ovf=1; res_data=0xF804 (260100 mod 65536).
REQ-038 Start ignored: extra start pulses during RUN and OUT -> exactly one frame; mac_en total high count = 4.
REQ-039 Mid-frame reset: rst asserted on the 2nd RUN cycle -> mac_en=0 immediately; no res_valid; the next start gives res_data=60 with the sticky bit cleared.
REQ-040 Back-to-back: start on the cycle after the OUT handshake -> second frame timing identical to the first; res_data updates only at the second SETTLE->OUT edge.

Source files
------------

// File: rtl/mac_result_reader.sv
// Sequences one MAC accumulation frame (clear, LEN enables, settle), then presents the
// captured accumulator and overflow flag on a valid/ready result port.
module mac_result_reader #(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             mac_rst,
  output logic             mac_en,
  input  logic [ACC_W-1:0] ac_val,
  input  logic             cout,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, SETTLE, OUT} state_t;

  localparam logic [7:0] LAST_STEP = 8'(LEN - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] step;
  logic       sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CLR;
      CLR:     state_next = RUN;
      RUN:     if (step == LAST_STEP) state_next = SETTLE;
      SETTLE:  state_next = OUT;
      OUT:     if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SETTLE always leads to OUT, so capturing during SETTLE lands exactly on the SETTLE->OUT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step     <= '0;
      sticky   <= 1'b0;
      res_data <= '0;
      res_ovf  <= 1'b0;
    end else begin
      unique case (state)
        CLR: begin
          step   <= '0;
          sticky <= 1'b0;
        end
        RUN: begin
          step   <= step + 8'd1;
          sticky <= sticky | cout;
        end
        SETTLE: begin
          sticky   <= sticky | cout;
          res_data <= ac_val;
          res_ovf  <= sticky | cout;
        end
        default: begin
          step <= step;
        end
      endcase
    end
  end

  always_comb begin
    mac_rst   = (state == CLR);
    mac_en    = (state == RUN);
    res_valid = (state == OUT);
    busy      = (state != IDLE);
  end

endmodule
